rnd_check: RTL and testbench

Receive-side checker for the team's LFSR pseudo-random generators (`rnd1`/`rnd8`/`rndx` family). It accepts a serial bit stream, self-synchronises by seeding its own LFSR from the first `WIDTH` received bits, then predicts every following bit and flags mismatches. It sits at the far end of a link or loopback path driven by a generator with the same polynomial, and reports lock status and a saturating error count.

---
 rtl/rnd_check.sv | 126 ++++++++++++
 tb/tb_rnd_check.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rnd_check.sv
// Receive-side LFSR stream checker: self-seeds from the first WIDTH valid bits,
// then predicts each following bit and tracks lock, per-bit errors and a saturating count.
module rnd_check #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] TAPS      = 32'h80200003,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned ERR_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_count
);

    localparam int unsigned SCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned WCW = $clog2(WINDOW);
    localparam int unsigned ECW = $clog2(ERR_LIMIT + 1);

    localparam logic [SCW-1:0] SEED_LAST = SCW'(WIDTH - 1);
    localparam logic [WCW-1:0] WIN_LAST  = WCW'(WINDOW - 1);
    localparam logic [ECW-1:0] ERR_LAST  = ECW'(ERR_LIMIT - 1);

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [SCW-1:0]   seed_cnt_q, seed_cnt_d;
    logic [WCW-1:0]   win_cnt_q, win_cnt_d;
    logic [ECW-1:0]   win_errs_q, win_errs_d;
    logic             err_q, err_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             fb;

    assign fb = ^(lfsr_q & TAPS[WIDTH-1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEED;
            lfsr_q     <= '0;
            seed_cnt_q <= '0;
            win_cnt_q  <= '0;
            win_errs_q <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seed_cnt_q <= seed_cnt_d;
            win_cnt_q  <= win_cnt_d;
            win_errs_q <= win_errs_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        seed_cnt_d = seed_cnt_q;
        win_cnt_d  = win_cnt_q;
        win_errs_d = win_errs_q;
        err_d      = 1'b0;

        case (state_q)
            SEED: begin
                if (din_valid) begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], din};
                    if (seed_cnt_q == SEED_LAST) begin
                        seed_cnt_d = '0;
                        // an all-zero seed would lock the LFSR up, so keep seeding
                        if (lfsr_d != '0) begin
                            state_d = CHECK;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (din_valid) begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], fb};
                    err_d  = (din != fb);
                    if (err_d) begin
                        win_errs_d = win_errs_q + 1'b1;
                    end
                    if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d  = '0;
                        win_errs_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                    end
                    // limit takes precedence over the window wrap on the same bit
                    if (err_d && (win_errs_q == ERR_LAST)) begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_errs_d = '0;
                    end
                end
            end
            default: state_d = SEED;
        endcase

        if (clear) begin
            err_cnt_d = {15'd0, err_d};
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_comb begin
        locked    = (state_q == CHECK);
        err       = err_q;
        err_count = err_cnt_q;
    end

endmodule

// File: tb/tb_rnd_check.sv
// Directed bench for rnd_check: seeding, tracking, errors, lock loss, window edge,
// gaps, clear and reset; a second instance is driven alongside to reach saturation.
module tb_rnd_check;

    localparam logic [31:0] TAPS = 32'h80200003;

    logic        clk = 1'b0;
    logic        reset_n, din, din_valid, clear;
    logic        locked, err;
    logic [15:0] err_count;

    logic        sat_rst_n, din_s, din_valid_s;
    logic        sat_lock, sat_err;
    logic [15:0] sat_cnt;

    int          checks = 0;
    int          errors = 0;
    int          chk = 0;
    int          errs_seen = 0;
    logic [31:0] g = 32'hF1928374;
    logic [31:0] sat_g = 32'hF1928374;
    int          sat_n = 0;
    logic        sat_run = 1'b0;
    logic [15:0] sat_exp = '0;

    always #5 clk = ~clk;

    rnd_check #(.WIDTH(32), .TAPS(TAPS), .WINDOW(256), .ERR_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked), .err(err), .err_count(err_count)
    );

    rnd_check #(.WIDTH(32), .TAPS(TAPS), .WINDOW(256), .ERR_LIMIT(256)) sat_dut (
        .clk(clk), .reset_n(sat_rst_n), .din(din_s), .din_valid(din_valid_s), .clear(1'b0),
        .locked(sat_lock), .err(sat_err), .err_count(sat_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Saturation instance: inverts bits 0..254 of every 256-bit window once locked.
    task automatic sat_drive();
        logic sb, inj;
        if (sat_run) begin
            sb    = ^(sat_g & TAPS);
            sat_g = {sat_g[30:0], sb};
            inj   = (sat_n >= 32) && (((sat_n - 32) % 256) != 255);
            din_s = inj ? ~sb : sb;
            din_valid_s = 1'b1;
            if (inj && sat_exp != 16'hFFFF) sat_exp++;
            sat_n++;
        end else begin
            din_s = 1'b0;
            din_valid_s = 1'b0;
        end
    endtask

    task automatic send(input logic b, input logic v);
        din = b;
        din_valid = v;
        sat_drive();
        @(posedge clk);
        #1;
        if (err !== 1'b0) errs_seen++;
    endtask

    task automatic nb(output logic b);
        b = ^(g & TAPS);
        g = {g[30:0], b};
    endtask

    task automatic good(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            nb(b);
            send(b, 1'b1);
            chk++;
        end
    endtask

    task automatic bad();
        logic b;
        nb(b);
        send(~b, 1'b1);
        chk++;
    endtask

    task automatic pad_window();
        if ((chk % 256) != 0) good(256 - (chk % 256));
    endtask

    task automatic gappy(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 2) == 0) send(1'($urandom_range(0, 1)), 1'b0);
            nb(b);
            send(b, 1'b1);
        end
    endtask

    initial begin
        reset_n = 1'b0; sat_rst_n = 1'b0;
        din = 1'b0; din_valid = 1'b0; clear = 1'b0;
        din_s = 1'b0; din_valid_s = 1'b0;
        repeat (3) send(1'b0, 1'b0);
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_count", {16'd0, err_count}, 32'd0);
        reset_n = 1'b1; sat_rst_n = 1'b1; sat_run = 1'b1;

        // All-zero seed must not lock
        repeat (32) send(1'b0, 1'b1);
        check("zero_seed_unlocked", {31'd0, locked}, 32'd0);

        good(31);
        check("seed31_unlocked", {31'd0, locked}, 32'd0);
        good(1);
        check("seed32_locked", {31'd0, locked}, 32'd1);
        chk = 0;

        errs_seen = 0;
        good(10000);
        check("track_err_pulses", errs_seen, 0);
        check("track_count", {16'd0, err_count}, 32'd0);
        check("track_locked", {31'd0, locked}, 32'd1);

        bad();
        check("flip_err", {31'd0, err}, 32'd1);
        check("flip_count", {16'd0, err_count}, 32'd1);
        check("flip_locked", {31'd0, locked}, 32'd1);
        errs_seen = 0;
        good(1);
        check("flip_err_one_cycle", {31'd0, err}, 32'd0);
        good(20);
        check("flip_after_pulses", errs_seen, 0);
        check("flip_after_count", {16'd0, err_count}, 32'd1);
        pad_window();

        clear = 1'b1;
        send(1'b0, 1'b0);
        clear = 1'b0;
        check("clear_count", {16'd0, err_count}, 32'd0);
        check("clear_keeps_lock", {31'd0, locked}, 32'd1);

        repeat (7) bad();
        check("loss7_locked", {31'd0, locked}, 32'd1);
        check("loss7_count", {16'd0, err_count}, 32'd7);
        bad();
        check("loss8_unlocked", {31'd0, locked}, 32'd0);
        check("loss8_err", {31'd0, err}, 32'd1);
        check("loss8_count", {16'd0, err_count}, 32'd8);

        good(31);
        check("relock31_unlocked", {31'd0, locked}, 32'd0);
        good(1);
        check("relock32_locked", {31'd0, locked}, 32'd1);
        chk = 0;

        repeat (7) bad();
        pad_window();
        bad();
        check("winA_locked", {31'd0, locked}, 32'd1);
        check("winA_count", {16'd0, err_count}, 32'd16);

        pad_window();
        repeat (7) bad();
        good(255 - (chk % 256));
        check("winB_bit254_locked", {31'd0, locked}, 32'd1);
        bad();
        check("winB_bit255_unlocked", {31'd0, locked}, 32'd0);
        check("winB_count", {16'd0, err_count}, 32'd24);

        gappy(31);
        check("gap31_unlocked", {31'd0, locked}, 32'd0);
        gappy(1);
        check("gap32_locked", {31'd0, locked}, 32'd1);
        errs_seen = 0;
        gappy(200);
        check("gap_err_pulses", errs_seen, 0);
        check("gap_count", {16'd0, err_count}, 32'd24);
        check("gap_locked", {31'd0, locked}, 32'd1);

        clear = 1'b1;
        bad();
        clear = 1'b0;
        check("clear_err_count", {16'd0, err_count}, 32'd1);
        check("clear_err_pulse", {31'd0, err}, 32'd1);
        check("clear_err_locked", {31'd0, locked}, 32'd1);

        // Asynchronous reset mid-cycle while err is high
        bad();
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_locked", {31'd0, locked}, 32'd0);
        check("areset_err", {31'd0, err}, 32'd0);
        check("areset_count", {16'd0, err_count}, 32'd0);
        send(1'b0, 1'b0);
        reset_n = 1'b1;
        good(32);
        check("post_reset_lock", {31'd0, locked}, 32'd1);
        good(1);
        check("post_reset_err", {31'd0, err}, 32'd0);

        check("sat_mid_count", {16'd0, sat_cnt}, {16'd0, sat_exp});
        check("sat_mid_locked", {31'd0, sat_lock}, 32'd1);
        while (sat_n < 66100) send(1'b0, 1'b0);
        check("sat_count", {16'd0, sat_cnt}, 32'h0000FFFF);
        check("sat_locked", {31'd0, sat_lock}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
